// File: rtl/video_tx_pkg.sv
// Shared types and constants for the video transmit timing core.
// Bar colours are 8-bit-per-channel {b,g,r}; they are MSB-aligned to CW where they are used.
package video_tx_pkg;

  typedef enum logic [1:0] {
    BARS  = 2'd0,
    RAMP  = 2'd1,
    CHECK = 2'd2,
    SOLID = 2'd3
  } pattern_e;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'h00FFFF;
  localparam logic [23:0] BAR_CYAN    = 24'hFFFF00;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'h0000FF;
  localparam logic [23:0] BAR_BLUE    = 24'hFF0000;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic int timing_total(input int front, input int sync,
                                      input int back, input int active);
    return front + sync + back + active;
  endfunction

  // Index 8 and above is the remainder strip to the right of the last bar.
  function automatic logic [23:0] bar_color(input logic [3:0] idx);
    case (idx)
      4'd0:    return BAR_WHITE;
      4'd1:    return BAR_YELLOW;
      4'd2:    return BAR_CYAN;
      4'd3:    return BAR_GREEN;
      4'd4:    return BAR_MAGENTA;
      4'd5:    return BAR_RED;
      4'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_tx_timing_core_if.sv
// Pixel stream handshake between the upstream resync FIFO and the timing core.
// master = pixel source, slave = timing core.
interface video_tx_timing_core_if #(
  parameter int CW = 8
) ();

  logic              pix_valid;
  logic [3*CW-1:0]   pix_data;
  logic              pix_ready;

  modport master (
    output pix_valid,
    output pix_data,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    output pix_ready
  );

endinterface

// File: rtl/video_test_pattern.sv
// Test pattern generator: bars, ramp, checkerboard or solid from raster position.
// Output is registered and forced to zero when en is low, so it can be OR-merged.
module video_test_pattern
  import video_tx_pkg::*;
#(
  parameter int          CW          = 8,
  parameter int          H_ACTIVE    = 1280,
  parameter int          CHECK_LOG2  = 4,
  parameter logic [23:0] SOLID_COLOR = 24'h808080
) (
  input  logic            pixel_clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic [12:0]     x,
  input  logic [12:0]     y,
  input  pattern_e        sel,
  output logic [3*CW-1:0] rgb_p1
);

  localparam int BAR_W = H_ACTIVE / 8;

  function automatic logic [CW-1:0] scale8(input logic [7:0] c);
    logic [CW+7:0] t;
    t = {c, {CW{1'b0}}};
    return t[CW+7 -: CW];
  endfunction

  function automatic logic [3*CW-1:0] scale_bgr(input logic [23:0] c);
    return {scale8(c[23:16]), scale8(c[15:8]), scale8(c[7:0])};
  endfunction

  logic [3:0]      bar_idx;
  logic            chk_bit;
  logic [CW-1:0]   ramp;
  logic [3*CW-1:0] pat_p0;

  always_comb begin
    bar_idx = (BAR_W == 0) ? 4'd8 : 4'd0;
    for (int k = 1; k <= 8; k++) begin
      if (BAR_W != 0 && x >= 13'(k * BAR_W)) bar_idx = 4'(k);
    end
    chk_bit = 1'((x ^ y) >> CHECK_LOG2);
    ramp    = CW'(x);
    pat_p0  = '0;
    unique case (sel)
      BARS:  pat_p0 = scale_bgr(bar_color(bar_idx));
      RAMP:  pat_p0 = {ramp, ramp, ramp};
      CHECK: pat_p0 = chk_bit ? scale_bgr(BAR_WHITE) : '0;
      SOLID: pat_p0 = scale_bgr(SOLID_COLOR);
      default: pat_p0 = '0;
    endcase
  end

  // p0 -> p1: aligned with the live pixel register in the core
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) rgb_p1 <= '0;
    else          rgb_p1 <= en ? pat_p0 : '0;
  end

endmodule

// File: rtl/video_tx_timing_core.sv
// Programmable raster timing for the ADV7513 parallel port, sourcing live pixels
// from the resync FIFO or a test pattern, with frame-boundary source switching.
module video_tx_timing_core
  import video_tx_pkg::*;
#(
  parameter int          CW            = 8,
  parameter int          H_FRONT       = 110,
  parameter int          H_SYNC        = 40,
  parameter int          H_BACK        = 220,
  parameter int          H_ACTIVE      = 1280,
  parameter int          V_FRONT       = 5,
  parameter int          V_SYNC        = 5,
  parameter int          V_BACK        = 20,
  parameter int          V_ACTIVE      = 720,
  parameter logic        HS_POL        = 1'b0,
  parameter logic        VS_POL        = 1'b0,
  parameter int          LINE_REQ_LEAD = 16,
  parameter int          CHECK_LOG2    = 4,
  parameter logic [23:0] SOLID_COLOR   = 24'h808080
) (
  input  logic                    pixel_clk,
  input  logic                    reset_n,
  input  logic                    src_ready,
  input  logic [1:0]              pattern_sel,
  video_tx_timing_core_if.slave   pix,
  output logic                    line_req,
  output logic                    frame_start,
  input  logic                    clr_underflow,
  output logic                    underflow,
  output logic                    live,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic [CW-1:0]           data_r,
  output logic [CW-1:0]           data_g,
  output logic [CW-1:0]           data_b
);

  localparam int HBLANK = timing_total(H_FRONT, H_SYNC, H_BACK, 0);
  localparam int HTOTAL = timing_total(H_FRONT, H_SYNC, H_BACK, H_ACTIVE);
  localparam int VBLANK = timing_total(V_FRONT, V_SYNC, V_BACK, 0);
  localparam int VTOTAL = timing_total(V_FRONT, V_SYNC, V_BACK, V_ACTIVE);

  logic [12:0]     h_cnt, v_cnt;
  logic [12:0]     x_pos, y_pos;
  logic            h_act, v_act, active;
  logic            hs_zone, vs_zone, frame_pos;
  logic            pix_ready_c, pat_en;
  pattern_e        sel_q;
  logic [3*CW-1:0] pix_p1, pat_p1;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == 13'(HTOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == 13'(VTOTAL - 1)) ? 13'd0 : v_cnt + 13'd1;
    end else begin
      h_cnt <= h_cnt + 13'd1;
    end
  end

  always_comb begin
    h_act       = h_cnt >= 13'(HBLANK);
    v_act       = v_cnt >= 13'(VBLANK);
    active      = h_act && v_act;
    hs_zone     = (h_cnt >= 13'(H_FRONT)) && (h_cnt < 13'(H_FRONT + H_SYNC));
    vs_zone     = (v_cnt >= 13'(V_FRONT)) && (v_cnt < 13'(V_FRONT + V_SYNC));
    frame_pos   = (h_cnt == 13'd0) && (v_cnt == 13'd0);
    x_pos       = h_cnt - 13'(HBLANK);
    y_pos       = v_cnt - 13'(VBLANK);
    pix_ready_c = active && live;
    pat_en      = active && !live;
  end

  assign pix.pix_ready = pix_ready_c;
  assign line_req      = (h_cnt == 13'(HBLANK - LINE_REQ_LEAD)) && v_act && live;

  // p0 -> p1: sync, enable and source selection registered with the pixel data
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      live        <= 1'b0;
      sel_q       <= BARS;
      underflow   <= 1'b0;
      frame_start <= 1'b0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
    end else begin
      if (frame_pos) begin
        live  <= src_ready;
        sel_q <= pattern_e'(pattern_sel);
      end
      if (pix_ready_c && !pix.pix_valid) underflow <= 1'b1;
      else if (clr_underflow)            underflow <= 1'b0;
      frame_start <= frame_pos;
      de          <= active;
      hsync       <= hs_zone ? HS_POL : ~HS_POL;
      vsync       <= vs_zone ? VS_POL : ~VS_POL;
    end
  end

  // A starved live pixel is sent as black rather than stale data.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) pix_p1 <= '0;
    else          pix_p1 <= (pix_ready_c && pix.pix_valid) ? pix.pix_data : '0;
  end

  video_test_pattern #(
    .CW          (CW),
    .H_ACTIVE    (H_ACTIVE),
    .CHECK_LOG2  (CHECK_LOG2),
    .SOLID_COLOR (SOLID_COLOR)
  ) u_pattern (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .en        (pat_en),
    .x         (x_pos),
    .y         (y_pos),
    .sel       (sel_q),
    .rgb_p1    (pat_p1)
  );

  // Both sources are zero outside their own active cycles, so OR is a clean merge.
  assign {data_b, data_g, data_r} = pix_p1 | pat_p1;

endmodule
